// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: data hazards, MDU occupancy, eret guard, exception entry.
// Optional MDU busy tracking is built only when PIPE_MDU_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_tuse_rs,
  input  logic [1:0] id_tuse_rt,
  input  logic [4:0] ex_waddr,
  input  logic [4:0] mem_waddr,
  input  logic [1:0] ex_tnew,
  input  logic [1:0] mem_tnew,
  input  logic       id_md,
  input  logic       ex_md_start,
  input  logic       ex_md_div,
  input  logic       id_eret,
  input  logic       ex_cp0we,
  input  logic       mem_cp0we,
  input  logic       int_req,
  output logic       stall,
  output logic       idex_flush,
  output logic       pipe_req,
  output logic       md_busy,
  output logic [3:0] md_count
);

  typedef enum logic [0:0] {StRun, StSettle} state_e;

  state_e state_q, state_d;
  logic   stall_rs, stall_rt, stall_md, stall_eret;

  assign stall_rs = (id_rs != 5'd0) &&
                    (((id_rs == ex_waddr) && (id_tuse_rs < ex_tnew)) ||
                     ((id_rs == mem_waddr) && (id_tuse_rs < mem_tnew)));
  assign stall_rt = (id_rt != 5'd0) &&
                    (((id_rt == ex_waddr) && (id_tuse_rt < ex_tnew)) ||
                     ((id_rt == mem_waddr) && (id_tuse_rt < mem_tnew)));
  assign stall_eret = id_eret && (ex_cp0we || mem_cp0we);

`ifdef PIPE_MDU_EN
  logic [3:0] md_count_q, md_count_d;

  // A mult/div flushed by exception entry never reaches the MDU, so it must not load.
  always_comb begin
    md_count_d = md_count_q;
    if (ex_md_start && (md_count_q == 4'd0) && !pipe_req) begin
      md_count_d = ex_md_div ? DIV_CYCLES[3:0] : MULT_CYCLES[3:0];
    end else if (md_count_q != 4'd0) begin
      md_count_d = md_count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_count_q <= 4'd0;
    end else begin
      md_count_q <= md_count_d;
    end
  end

  assign md_count = md_count_q;
  assign md_busy  = (md_count_q != 4'd0) || ex_md_start;
  assign stall_md = id_md && md_busy;
`else
  logic unused_md;
  assign unused_md = ^{id_md, ex_md_start, ex_md_div};
  assign md_count  = 4'd0;
  assign md_busy   = 1'b0;
  assign stall_md  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (int_req) state_d = StSettle;
      StSettle: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // SETTLE masks int_req while CP0 raises EXL, so one exception enters exactly once.
  always_comb begin
    pipe_req   = (state_q == StRun) && int_req;
    stall      = (stall_rs | stall_rt | stall_md | stall_eret) && !pipe_req;
    idex_flush = stall;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue scoreboard of expected outputs.
// MDU expectations follow PIPE_MDU_EN so the bench suits either build.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_MDU_EN
  localparam bit MduEn = 1'b1;
`else
  localparam bit MduEn = 1'b0;
`endif

  logic       clk, reset_n;
  logic [4:0] id_rs, id_rt, ex_waddr, mem_waddr;
  logic [1:0] id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic       id_md, ex_md_start, ex_md_div, id_eret, ex_cp0we, mem_cp0we, int_req;
  logic       stall, idex_flush, pipe_req, md_busy;
  logic [3:0] md_count;

  typedef struct {
    string      tag;
    logic       stall;
    logic       pipe_req;
    logic       md_busy;
    logic [3:0] md_count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_tuse_rs (id_tuse_rs),
    .id_tuse_rt (id_tuse_rt),
    .ex_waddr   (ex_waddr),
    .mem_waddr  (mem_waddr),
    .ex_tnew    (ex_tnew),
    .mem_tnew   (mem_tnew),
    .id_md      (id_md),
    .ex_md_start(ex_md_start),
    .ex_md_div  (ex_md_div),
    .id_eret    (id_eret),
    .ex_cp0we   (ex_cp0we),
    .mem_cp0we  (mem_cp0we),
    .int_req    (int_req),
    .stall      (stall),
    .idex_flush (idex_flush),
    .pipe_req   (pipe_req),
    .md_busy    (md_busy),
    .md_count   (md_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_tuse_rs = '0; id_tuse_rt = '0;
    ex_waddr = '0; mem_waddr = '0; ex_tnew = '0; mem_tnew = '0;
    id_md = 1'b0; ex_md_start = 1'b0; ex_md_div = 1'b0;
    id_eret = 1'b0; ex_cp0we = 1'b0; mem_cp0we = 1'b0; int_req = 1'b0;
  endtask

  task automatic cmp1(input string tag, input string name, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed %b expected %b", tag, name, obs, expv);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    e = exp_q.pop_front();
    cmp1(e.tag, "stall", stall, e.stall);
    cmp1(e.tag, "idex_flush", idex_flush, e.stall);
    cmp1(e.tag, "pipe_req", pipe_req, e.pipe_req);
    cmp1(e.tag, "md_busy", md_busy, e.md_busy);
    checks++;
    assert (md_count === e.md_count) else begin
      errors++;
      $error("FAIL %s.md_count observed %0d expected %0d", e.tag, md_count, e.md_count);
    end
  endtask

  // Inputs are already driven for this cycle; push the expectation, let logic settle, compare.
  task automatic step(input string tag, input logic s, input logic p, input logic b,
                      input logic [3:0] c);
    exp_t e;
    e.tag = tag; e.stall = s; e.pipe_req = p; e.md_busy = b; e.md_count = c;
    exp_q.push_back(e);
    #1;
    compare_front();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    step("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;

    // Data hazards
    @(negedge clk);
    ex_waddr = 5'd8; ex_tnew = 2'd2; id_rs = 5'd8; id_tuse_rs = 2'd0;
    step("load_use", 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    id_rs = 5'd0;
    step("rs_zero", 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    id_rs = 5'd8; id_tuse_rs = 2'd3;
    step("tuse3", 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    clear_inputs();
    mem_waddr = 5'd9; mem_tnew = 2'd1; id_rt = 5'd9; id_tuse_rt = 2'd0;
    step("mem_rt", 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    id_tuse_rt = 2'd1;
    step("mem_rt_equal", 1'b0, 1'b0, 1'b0, 4'd0);

    // mult followed by mfhi
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      clear_inputs();
      id_md = 1'b1;
      ex_md_start = (k == 0);
      step($sformatf("mult_c%0d", k), MduEn && (k <= 5), 1'b0, MduEn && (k <= 5),
           (MduEn && k >= 1 && k <= 5) ? 4'(6 - k) : 4'd0);
    end

    // div, then asynchronous reset when the count reaches 4
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      clear_inputs();
      ex_md_start = (k == 0);
      ex_md_div = (k == 0);
      step($sformatf("div_c%0d", k), 1'b0, 1'b0, MduEn,
           (MduEn && k >= 1) ? 4'(11 - k) : 4'd0);
    end
    #1 reset_n = 1'b0;
    step("div_async_rst", 1'b0, 1'b0, 1'b0, 4'd0);
    #1 reset_n = 1'b1;

    // Interrupt during a load-use stall
    @(negedge clk);
    clear_inputs();
    ex_waddr = 5'd8; ex_tnew = 2'd2; id_rs = 5'd8; id_tuse_rs = 2'd0; int_req = 1'b1;
    step("int_entry", 1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    step("int_settle", 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    step("int_again", 1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    clear_inputs();
    step("int_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // Exception together with a mult start: the counter must not load
    @(negedge clk);
    int_req = 1'b1; ex_md_start = 1'b1;
    step("int_md_start", 1'b0, 1'b1, MduEn, 4'd0);
    @(negedge clk);
    clear_inputs();
    step("int_md_noload", 1'b0, 1'b0, 1'b0, 4'd0);

    // Running counter continues through exception entry
    @(negedge clk);
    ex_md_start = 1'b1;
    step("run_start", 1'b0, 1'b0, MduEn, 4'd0);
    @(negedge clk);
    clear_inputs();
    int_req = 1'b1;
    step("run_int", 1'b0, 1'b1, MduEn, MduEn ? 4'd5 : 4'd0);
    for (int k = 4; k >= 0; k--) begin
      @(negedge clk);
      clear_inputs();
      step($sformatf("run_cnt%0d", k), 1'b0, 1'b0, MduEn && (k != 0),
           MduEn ? 4'(k) : 4'd0);
    end

    // eret guard
    @(negedge clk);
    id_eret = 1'b1; mem_cp0we = 1'b1;
    step("eret_mem", 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    mem_cp0we = 1'b0;
    step("eret_clear", 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    ex_cp0we = 1'b1;
    step("eret_ex", 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    clear_inputs();
    step("final_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
